// File: rtl/command_serializer.sv
// command_serializer: turns one structured command into the control-unit byte stream
// (opcode, then block and payload MSB first), paced by the consumer's `next` pulse.
// Optional feature macro: CMD_SER_RETRY_EN (re-strobe a byte on acknowledge timeout).
module command_serializer #(
  parameter int n_blocks    = 256,
  parameter int data_width  = 16,
  parameter int GAP         = 2,
  parameter int ACK_TIMEOUT = 64,
  parameter int MAX_RETRIES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_opcode,
  input  logic [15:0] cmd_block,
  input  logic [47:0] cmd_payload,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        next,
  output logic        busy,
  output logic        done,
  output logic        unknown_cmd,
  output logic        timeout_err,
  output logic [2:0]  fsm_state
);

  // Command codes, kept in step with controller.vh.
  localparam logic [7:0] COMMAND_WRITE_BLOCK_INSTR   = 8'h01;
  localparam logic [7:0] COMMAND_WRITE_BLOCK_REG_0   = 8'h02;
  localparam logic [7:0] COMMAND_WRITE_BLOCK_REG_1   = 8'h03;
  localparam logic [7:0] COMMAND_UPDATE_BLOCK_REG_0  = 8'h04;
  localparam logic [7:0] COMMAND_UPDATE_BLOCK_REG_1  = 8'h05;
  localparam logic [7:0] COMMAND_ALLOC_DELAY         = 8'h06;
  localparam logic [7:0] COMMAND_SET_INPUT_GAIN      = 8'h07;
  localparam logic [7:0] COMMAND_SET_OUTPUT_GAIN     = 8'h08;
  localparam logic [7:0] COMMAND_SWAP_PIPELINES      = 8'h09;
  localparam logic [7:0] COMMAND_RESET_PIPELINE      = 8'h0A;
  localparam logic [7:0] COMMAND_COMMIT_REG_UPDATES  = 8'h0B;

  localparam int BLOCK_BYTES = (n_blocks > 256) ? 2 : 1;
  localparam int DATA_BYTES  = (data_width == 24) ? 3 : 2;
  localparam int GW          = $clog2(GAP + 1);
  localparam int TW          = $clog2(ACK_TIMEOUT + 1);
  localparam int RW          = $clog2(MAX_RETRIES + 2);
`ifdef CMD_SER_RETRY_EN
  localparam int RETRY_LIMIT = MAX_RETRIES;
`else
  localparam int RETRY_LIMIT = 0;
`endif
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(RETRY_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STROBE = 3'd1,
    S_ACK    = 3'd2,
    S_GAP    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [63:0]     ops;
  logic [3:0]      remaining;
  logic [GW-1:0]   gap_cnt;
  logic [TW-1:0]   timer;
  logic [RW-1:0]   retries;

  logic [15:0]     blk_aligned;
  logic [23:0]     data_aligned;
  logic [63:0]     dec_ops;
  logic [3:0]      dec_len;
  logic            dec_unknown;

  logic            accept;
  logic            ack_hit;
  logic            timer_hit;
  logic            retry_ok;
  logic            gap_end;
  logic            last_byte;

  // Operand decode: operand bytes are packed left-aligned so the serializer
  // only ever shifts out the top byte, whatever the command layout.
  always_comb begin
    blk_aligned  = (BLOCK_BYTES == 2) ? cmd_block : {cmd_block[7:0], 8'h00};
    data_aligned = (DATA_BYTES == 3) ? cmd_payload[23:0] : {cmd_payload[15:0], 8'h00};
    dec_ops      = 64'd0;
    dec_len      = 4'd0;
    dec_unknown  = 1'b0;
    case (cmd_opcode)
      COMMAND_WRITE_BLOCK_INSTR: begin
        dec_ops = {blk_aligned, 48'd0} | ({cmd_payload[31:0], 32'd0} >> (8 * BLOCK_BYTES));
        dec_len = 4'(BLOCK_BYTES + 4);
      end
      COMMAND_WRITE_BLOCK_REG_0, COMMAND_WRITE_BLOCK_REG_1,
      COMMAND_UPDATE_BLOCK_REG_0, COMMAND_UPDATE_BLOCK_REG_1: begin
        dec_ops = {blk_aligned, 48'd0} | ({data_aligned, 40'd0} >> (8 * BLOCK_BYTES));
        dec_len = 4'(BLOCK_BYTES + DATA_BYTES);
      end
      COMMAND_ALLOC_DELAY: begin
        dec_ops = {cmd_payload, 16'd0};
        dec_len = 4'd6;
      end
      COMMAND_SET_INPUT_GAIN, COMMAND_SET_OUTPUT_GAIN: begin
        dec_ops = {data_aligned, 40'd0};
        dec_len = 4'(DATA_BYTES);
      end
      COMMAND_SWAP_PIPELINES, COMMAND_RESET_PIPELINE, COMMAND_COMMIT_REG_UPDATES: begin
        dec_len = 4'd0;
      end
      default: dec_unknown = 1'b1;
    endcase
  end

  // Handshake: a command transfers on a cycle where cmd_valid && cmd_ready; each
  // byte is offered by a one-cycle out_valid and consumed by the first `next` seen in ACK.
  always_comb begin
    accept    = (state == S_IDLE) && cmd_valid;
    ack_hit   = (state == S_ACK) && next;
    timer_hit = (state == S_ACK) && !next && (timer == TIMER_LAST);
    retry_ok  = (retries != RETRY_MAX);
    gap_end   = (state == S_GAP) && (gap_cnt == GAP_LAST);
    last_byte = (remaining == 4'd0);
    state_n   = state;
    case (state)
      S_IDLE:   if (cmd_valid) state_n = S_STROBE;
      S_STROBE: state_n = S_ACK;
      S_ACK: begin
        if (next)           state_n = last_byte ? S_DONE : S_GAP;
        else if (timer_hit) state_n = retry_ok ? S_STROBE : S_IDLE;
      end
      S_GAP:    if (gap_end) state_n = S_STROBE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      out_byte    <= 8'd0;
      ops         <= 64'd0;
      remaining   <= 4'd0;
      gap_cnt     <= '0;
      timer       <= '0;
      retries     <= '0;
      unknown_cmd <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      unknown_cmd <= 1'b0;
      timeout_err <= 1'b0;

      if (accept) begin
        out_byte    <= cmd_opcode;
        ops         <= dec_ops;
        remaining   <= dec_len;
        unknown_cmd <= dec_unknown;
        retries     <= '0;
      end

      // Timer reads 0 in the strobe cycle, so a timeout re-strobe lands ACK_TIMEOUT later.
      if (state_n == S_STROBE) timer <= '0;
      else if (state == S_STROBE || state == S_ACK) timer <= timer + 1'b1;

      if (ack_hit) begin
        gap_cnt <= '0;
        retries <= '0;
      end else if (state == S_GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
      end

      if (timer_hit) begin
        if (retry_ok) retries <= retries + 1'b1;
        else          timeout_err <= 1'b1;
      end

      if (gap_end) begin
        out_byte  <= ops[63:56];
        ops       <= {ops[55:0], 8'h00};
        remaining <= remaining - 1'b1;
      end
    end
  end

  assign cmd_ready = (state == S_IDLE);
  assign out_valid = (state == S_STROBE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign fsm_state = state;

endmodule

// File: tb/tb_command_serializer.sv
// Bench for command_serializer: directed cases plus random commands checked against a
// byte-list / cycle-arithmetic reference model.
module tb_command_serializer;

  localparam int N_BLOCKS    = 256;
  localparam int DATA_WIDTH  = 16;
  localparam int GAP         = 2;
  localparam int ACK_TIMEOUT = 64;
  localparam int MAX_RETRIES = 3;
  localparam int BB = (N_BLOCKS > 256) ? 2 : 1;
  localparam int DB = (DATA_WIDTH == 24) ? 3 : 2;
`ifdef CMD_SER_RETRY_EN
  localparam int NRE = MAX_RETRIES;
`else
  localparam int NRE = 0;
`endif

  localparam logic [7:0] C_INSTR  = 8'h01;
  localparam logic [7:0] C_REG0   = 8'h02;
  localparam logic [7:0] C_REG1   = 8'h03;
  localparam logic [7:0] C_UPD0   = 8'h04;
  localparam logic [7:0] C_UPD1   = 8'h05;
  localparam logic [7:0] C_ALLOC  = 8'h06;
  localparam logic [7:0] C_IGAIN  = 8'h07;
  localparam logic [7:0] C_OGAIN  = 8'h08;
  localparam logic [7:0] C_SWAP   = 8'h09;
  localparam logic [7:0] C_RSTP   = 8'h0A;
  localparam logic [7:0] C_COMMIT = 8'h0B;

  logic [7:0] op_tab [11] = '{C_INSTR, C_REG0, C_REG1, C_UPD0, C_UPD1, C_ALLOC,
                              C_IGAIN, C_OGAIN, C_SWAP, C_RSTP, C_COMMIT};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_opcode = 8'd0;
  logic [15:0] cmd_block = 16'd0;
  logic [47:0] cmd_payload = 48'd0;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        next;
  logic        busy;
  logic        done;
  logic        unknown_cmd;
  logic        timeout_err;
  logic [2:0]  fsm_state;

  logic resp_next = 1'b0;
  logic stray_next = 1'b0;
  logic idle_next = 1'b0;
  assign next = resp_next | stray_next | idle_next;

  command_serializer #(
    .n_blocks(N_BLOCKS), .data_width(DATA_WIDTH), .GAP(GAP),
    .ACK_TIMEOUT(ACK_TIMEOUT), .MAX_RETRIES(MAX_RETRIES)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_block(cmd_block), .cmd_payload(cmd_payload),
    .out_byte(out_byte), .out_valid(out_valid), .next(next), .busy(busy),
    .done(done), .unknown_cmd(unknown_cmd), .timeout_err(timeout_err),
    .fsm_state(fsm_state)
  );

  // clock / cycle index
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  // scoreboard state
  logic [7:0] exp_q[$];
  logic [7:0] got_b[$];
  int         got_t[$];
  int         done_t[$];
  int         unk_t[$];
  int         terr_t[$];

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      got_b.push_back(out_byte);
      got_t.push_back(cyc);
    end
    if (done === 1'b1) done_t.push_back(cyc);
    if (unknown_cmd === 1'b1) unk_t.push_back(cyc);
    if (timeout_err === 1'b1) terr_t.push_back(cyc);
  end

  // control-unit responder: acks the first ack_limit strobes of an epoch, ack_dly cycles late
  int ack_dly = 1;
  int ack_limit = 0;
  int ack_epoch = 0;
  bit stray_en = 1'b0;
  int wait_cnt = 0;
  int since = 100;
  int seen_epoch = 0;
  int acked = 0;
  initial begin
    forever begin
      @(negedge clk);
      resp_next = 1'b0;
      if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) resp_next = 1'b1;
      end
      if (out_valid === 1'b1) since = 0;
      else if (since < 100) since++;
      stray_next = stray_en && (since == 0 || since == 2 || since == 3);
      if (out_valid === 1'b1) begin
        if (seen_epoch != ack_epoch) begin
          seen_epoch = ack_epoch;
          acked = 0;
        end
        if (acked < ack_limit) begin
          acked++;
          wait_cnt = ack_dly;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic clear_obs();
    got_b.delete();
    got_t.delete();
    done_t.delete();
    unk_t.delete();
    terr_t.delete();
  endtask

  // Reference model: the byte list the control unit should receive.
  task automatic model(input logic [7:0] op, input logic [15:0] blk, input logic [47:0] pl,
                       output bit unk);
    int nblk;
    int npl;
    exp_q.delete();
    exp_q.push_back(op);
    unk = 1'b0;
    nblk = 0;
    npl = 0;
    case (op)
      C_INSTR: begin nblk = BB; npl = 4; end
      C_REG0, C_REG1, C_UPD0, C_UPD1: begin nblk = BB; npl = DB; end
      C_ALLOC: npl = 6;
      C_IGAIN, C_OGAIN: npl = DB;
      C_SWAP, C_RSTP, C_COMMIT: npl = 0;
      default: unk = 1'b1;
    endcase
    for (int i = nblk - 1; i >= 0; i--) exp_q.push_back(blk[8*i +: 8]);
    for (int i = npl - 1; i >= 0; i--) exp_q.push_back(pl[8*i +: 8]);
  endtask

  // Present a command and return its acceptance cycle.
  task automatic send(input logic [7:0] op, input logic [15:0] blk, input logic [47:0] pl,
                      input string tag, output int t0);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    check({tag, "_ready_before"}, cmd_ready, 1'b1);
    cmd_opcode = op;
    cmd_block = blk;
    cmd_payload = pl;
    cmd_valid = 1'b1;
    t0 = cyc;
    step();
    cmd_valid = 1'b0;
    cmd_opcode = 8'($urandom);
    cmd_block = 16'($urandom);
    cmd_payload = {16'($urandom), 32'($urandom)};
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic [15:0] blk, input logic [47:0] pl,
                         input int d, input string tag);
    bit unk;
    int t0;
    int n;
    int per;
    model(op, blk, pl, unk);
    clear_obs();
    ack_dly = d;
    ack_limit = 100;
    ack_epoch++;
    send(op, blk, pl, tag, t0);
    check({tag, "_ready_t1"}, cmd_ready, 1'b0);
    check({tag, "_busy_t1"}, busy, 1'b1);
    check({tag, "_unk_t1"}, unknown_cmd, unk);
    n = 0;
    while (done_t.size() == 0 && terr_t.size() == 0 && n < 600) begin
      step();
      n++;
    end
    check({tag, "_done_cnt"}, done_t.size(), 1);
    check({tag, "_busy_at_done"}, busy, 1'b1);
    check({tag, "_ready_at_done"}, cmd_ready, 1'b0);
    step();
    check({tag, "_ready_after"}, cmd_ready, 1'b1);
    check({tag, "_busy_after"}, busy, 1'b0);
    per = d + GAP + 1;
    check({tag, "_len"}, got_b.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_b.size()) begin
        check($sformatf("%s_byte%0d", tag, i), got_b[i], exp_q[i]);
        check($sformatf("%s_time%0d", tag, i), got_t[i], t0 + 1 + i * per);
      end
    end
    if (done_t.size() > 0)
      check({tag, "_done_time"}, done_t[0], t0 + 1 + (exp_q.size() - 1) * per + d + 1);
    check({tag, "_unk_cnt"}, unk_t.size(), unk ? 1 : 0);
    if (unk && unk_t.size() > 0) check({tag, "_unk_time"}, unk_t[0], t0 + 1);
    check({tag, "_terr_cnt"}, terr_t.size(), 0);
  endtask

  // Opcode acked, second byte never acked.
  task automatic run_timeout(input logic [7:0] op, input logic [15:0] blk, input logic [47:0] pl);
    bit unk;
    int t0;
    int n;
    int s2;
    model(op, blk, pl, unk);
    clear_obs();
    ack_dly = 1;
    ack_limit = 1;
    ack_epoch++;
    send(op, blk, pl, "tmo", t0);
    n = 0;
    while (terr_t.size() == 0 && n < 1000) begin
      step();
      n++;
    end
    s2 = t0 + 1 + (1 + GAP + 1);
    check("tmo_terr_cnt", terr_t.size(), 1);
    check("tmo_strobe_cnt", got_b.size(), 2 + NRE);
    for (int k = 1; k < got_b.size(); k++) begin
      check($sformatf("tmo_byte%0d", k), got_b[k], exp_q[1]);
      check($sformatf("tmo_time%0d", k), got_t[k], s2 + (k - 1) * ACK_TIMEOUT);
    end
    if (terr_t.size() > 0) check("tmo_terr_time", terr_t[0], s2 + (NRE + 1) * ACK_TIMEOUT);
    check("tmo_done_cnt", done_t.size(), 0);
    step();
    check("tmo_ready_after", cmd_ready, 1'b1);
    check("tmo_busy_after", busy, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_byte"}, out_byte, 8'h00);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_unknown"}, unknown_cmd, 1'b0);
    check({tag, "_timeout"}, timeout_err, 1'b0);
    check({tag, "_ready"}, cmd_ready, 1'b1);
  endtask

  initial begin
    int t0;
    int n;
    logic [7:0]  op;
    logic [15:0] blk;
    logic [47:0] pl;
    int d;

    // reset, with a command held on the inputs that must be ignored
    reset = 1'b1;
    cmd_valid = 1'b1;
    cmd_opcode = C_INSTR;
    cmd_block = 16'h00AB;
    repeat (3) step();
    check_reset_vals("rst");
    reset = 1'b0;
    cmd_valid = 1'b0;
    step();
    check("rst_no_accept", out_valid, 1'b0);
    check("rst_no_latch", out_byte, 8'h00);

    // directed cases
    run_cmd(C_INSTR, 16'h0012, 48'h0000_DEAD_BEEF, 1, "instr");
    run_cmd(C_ALLOC, 16'h0000, {24'h001000, 24'h000040}, 2, "alloc");
    run_cmd(C_SWAP, 16'h0000, 48'd0, 1, "swap");
    run_cmd(8'hFF, 16'h0000, 48'd0, 1, "unk_ff");
    run_cmd(C_IGAIN, 16'h0000, 48'h0000_0000_1234, 3, "igain");

    // stray next while idle, then strays in strobe/gap/done cycles
    clear_obs();
    idle_next = 1'b1;
    step();
    step();
    idle_next = 1'b0;
    step();
    check("idle_stray_ready", cmd_ready, 1'b1);
    check("idle_stray_nostrobe", got_b.size(), 0);
    stray_en = 1'b1;
    run_cmd(C_REG0, 16'h0077, 48'h0000_0000_ABCD, 1, "stray_reg");
    run_cmd(C_INSTR, 16'h00C3, 48'h0000_0102_0304, 1, "stray_instr");
    stray_en = 1'b0;

    run_timeout(C_REG1, 16'h005A, 48'h0000_0000_9876);

    // reset during the gap after the third byte
    clear_obs();
    ack_dly = 1;
    ack_limit = 100;
    ack_epoch++;
    send(C_INSTR, 16'h0034, 48'h0000_1122_3344, "rgap", t0);
    n = 0;
    while (got_b.size() < 3 && n < 100) begin
      step();
      n++;
    end
    check("rgap_third_strobe", got_b.size(), 3);
    step();
    step();
    reset = 1'b1;
    cmd_valid = 1'b1;
    cmd_opcode = C_SWAP;
    step();
    reset = 1'b0;
    cmd_valid = 1'b0;
    check_reset_vals("rgap");
    repeat (20) step();
    check("rgap_no_more_strobes", got_b.size(), 3);
    check("rgap_no_done", done_t.size(), 0);
    run_cmd(C_UPD1, 16'h0099, 48'h0000_0000_5566, 1, "rgap_next");

    // random commands
    for (int k = 0; k < 12; k++) begin
      n = $urandom_range(0, 11);
      op = (n == 11) ? 8'($urandom_range(12, 255)) : op_tab[n];
      blk = 16'($urandom);
      pl = {16'($urandom), 32'($urandom)};
      d = $urandom_range(1, 5);
      stray_en = (d == 1) && ($urandom_range(0, 1) == 1);
      run_cmd(op, blk, pl, d, $sformatf("rnd%0d", k));
    end
    stray_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
